// File: rtl/prbs_mon_pkg.sv
// Shared encodings for the PRBS link monitor.
// Channel state codes are visible on ch_state and must stay 2 bits.
package prbs_mon_pkg;

    localparam int STATE_W  = 2;
    localparam int STATUS_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } chan_state_e;

    localparam int SB_INJECT = 0;
    localparam int SB_HUNT   = 1;
    localparam int SB_LOCKED = 2;
    localparam int SB_LOST   = 3;

endpackage

// File: rtl/prbs_chan_mon.sv
// One channel of the link monitor.
// Covers lock FSM, run/window counters, saturating error count and LED.
module prbs_chan_mon
    import prbs_mon_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_CYC = 256,
    parameter int WIN      = 1024,
    parameter int LOSS_ERR = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               chk_valid,
    input  logic               prbs_error,
    input  logic               clear_evt,
    input  logic               blink,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               led
);

    localparam int RUN_W  = $clog2(LOCK_CYC);
    localparam int WIN_W  = $clog2(WIN);
    localparam int WERR_W = $clog2(LOSS_ERR + 1);

    chan_state_e       state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WERR_W-1:0] werr_q, werr_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              led_q, led_d;
    logic              err_ev;
    logic [WERR_W-1:0] werr_sum;

    always_comb begin
        err_ev    = chk_valid & prbs_error;
        state_d   = state_q;
        run_d     = run_q;
        win_d     = win_q;
        werr_d    = werr_q;
        err_cnt_d = err_cnt_q;
        werr_sum  = werr_q + WERR_W'(err_ev);
        led_d     = 1'b0;

        // Clear takes priority over an error landing in the same cycle.
        if (clear_evt) begin
            err_cnt_d = '0;
        end else if (err_ev && (state_q == ST_LOCKED || state_q == ST_LOST)
                     && err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        if (!enable) begin
            state_d = ST_IDLE;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_HUNT;
                    run_d   = '0;
                end
                ST_HUNT: begin
                    if (clear_evt || err_ev) begin
                        run_d = '0;
                    end else if (chk_valid) begin
                        if (run_q == RUN_W'(LOCK_CYC - 1)) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    // An error on the final window cycle is judged before the restart.
                    if (win_q == WIN_W'(WIN - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WIN_W'(1);
                        werr_d = werr_sum;
                    end
                    if (werr_sum >= WERR_W'(LOSS_ERR)) begin
                        state_d = ST_LOST;
                    end
                end
                ST_LOST: begin
                    if (clear_evt) begin
                        state_d = ST_HUNT;
                        run_d   = '0;
                    end
                end
            endcase
        end

        unique case (state_d)
            ST_LOCKED: led_d = ~err_ev;
            ST_LOST:   led_d = blink;
            default:   led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            run_q     <= '0;
            win_q     <= '0;
            werr_q    <= '0;
            err_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            err_cnt_q <= err_cnt_d;
            led_q     <= led_d;
        end
    end

    assign state   = state_q;
    assign err_cnt = err_cnt_q;
    assign led     = led_q;

endmodule

// File: rtl/prbs_link_monitor.sv
// Multi-channel PRBS link monitor: VIO edge detection, LED blink source,
// per-channel monitors and a registered status summary.
module prbs_link_monitor
    import prbs_mon_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int CNT_W    = 16,
    parameter int LOCK_CYC = 256,
    parameter int WIN      = 1024,
    parameter int LOSS_ERR = 4,
    parameter int BLINK_W  = 24
) (
    input  logic                   txusrclk2,
    input  logic                   reset,
    input  logic [NCH-1:0]         enable,
    input  logic [NCH-1:0]         chk_valid,
    input  logic [NCH-1:0]         prbs_error,
    input  logic                   inject,
    input  logic                   clear,
    output logic                   inject_pulse,
    output logic [STATE_W*NCH-1:0] ch_state,
    output logic [CNT_W*NCH-1:0]   err_cnt,
    output logic [NCH-1:0]         led,
    output logic [STATUS_W-1:0]    state_status
);

    logic                inj_s1_q, inj_s1_d, inj_s2_q, inj_s2_d;
    logic                clr_s1_q, clr_s1_d, clr_s2_q, clr_s2_d;
    logic                pulse_q, pulse_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic                inj_evt, clr_evt;
    logic                any_lost, any_hunt, any_en, all_lk;

    always_comb begin
        inj_s1_d = inject;
        inj_s2_d = inj_s1_q;
        clr_s1_d = clear;
        clr_s2_d = clr_s1_q;
        inj_evt  = inj_s1_q & ~inj_s2_q;
        clr_evt  = clr_s1_q & ~clr_s2_q;
        pulse_d  = inj_evt;
        blink_d  = blink_q + BLINK_W'(1);
    end

    always_comb begin
        any_lost = 1'b0;
        any_hunt = 1'b0;
        any_en   = 1'b0;
        all_lk   = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (ch_state[STATE_W*i +: STATE_W] == ST_LOST) any_lost = 1'b1;
            if (ch_state[STATE_W*i +: STATE_W] == ST_HUNT) any_hunt = 1'b1;
            if (enable[i]) begin
                any_en = 1'b1;
                if (ch_state[STATE_W*i +: STATE_W] != ST_LOCKED) all_lk = 1'b0;
            end
        end
        status_d            = '0;
        status_d[SB_LOST]   = any_lost;
        status_d[SB_LOCKED] = any_en & all_lk;
        status_d[SB_HUNT]   = any_hunt;
        status_d[SB_INJECT] = pulse_d;
    end

    always_ff @(posedge txusrclk2 or negedge reset) begin
        if (!reset) begin
            inj_s1_q <= 1'b0;
            inj_s2_q <= 1'b0;
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            pulse_q  <= 1'b0;
            blink_q  <= '0;
            status_q <= '0;
        end else begin
            inj_s1_q <= inj_s1_d;
            inj_s2_q <= inj_s2_d;
            clr_s1_q <= clr_s1_d;
            clr_s2_q <= clr_s2_d;
            pulse_q  <= pulse_d;
            blink_q  <= blink_d;
            status_q <= status_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        prbs_chan_mon #(
            .CNT_W    (CNT_W),
            .LOCK_CYC (LOCK_CYC),
            .WIN      (WIN),
            .LOSS_ERR (LOSS_ERR)
        ) u_ch (
            .clk        (txusrclk2),
            .rst_n      (reset),
            .enable     (enable[i]),
            .chk_valid  (chk_valid[i]),
            .prbs_error (prbs_error[i]),
            .clear_evt  (clr_evt),
            .blink      (blink_q[BLINK_W-1]),
            .state      (ch_state[STATE_W*i +: STATE_W]),
            .err_cnt    (err_cnt[CNT_W*i +: CNT_W]),
            .led        (led[i])
        );
    end

    assign inject_pulse = pulse_q;
    assign state_status = status_q;

endmodule

// File: tb/tb_prbs_link_monitor.sv
// Directed bench for prbs_link_monitor with hand-computed expectations.
module tb_prbs_link_monitor;

    localparam int NCH   = 8;
    localparam int CNT_W = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       en, vld, err;
    logic                 inj, clr;
    logic                 inject_pulse;
    logic [2*NCH-1:0]     ch_state;
    logic [CNT_W*NCH-1:0] err_cnt;
    logic [NCH-1:0]       led;
    logic [3:0]           state_status;

    int n_run;
    int n_fail;
    int cyc;

    prbs_link_monitor #(
        .NCH(NCH), .CNT_W(CNT_W), .LOCK_CYC(256),
        .WIN(1024), .LOSS_ERR(4), .BLINK_W(4)
    ) dut (
        .txusrclk2    (clk),
        .reset        (rst_n),
        .enable       (en),
        .chk_valid    (vld),
        .prbs_error   (err),
        .inject       (inj),
        .clear        (clr),
        .inject_pulse (inject_pulse),
        .ch_state     (ch_state),
        .err_cnt      (err_cnt),
        .led          (led),
        .state_status (state_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] st(input int i);
        return ch_state[2*i +: 2];
    endfunction

    function automatic logic [CNT_W-1:0] ec(input int i);
        return err_cnt[CNT_W*i +: CNT_W];
    endfunction

    initial begin
        logic seen0, seen1;
        int   npulse;
        n_run = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; en = '0; vld = '0; err = '0; inj = 1'b0; clr = 1'b0;
        repeat (3) tick();
        chk("rst_state", ch_state, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_led", led, 0);
        chk("rst_pulse", inject_pulse, 0);
        chk("rst_status", state_status, 0);

        // lock-up of all channels
        rst_n = 1'b1; en = 8'hFF; vld = 8'hFF; cyc = 0;
        tick();
        chk("hunt_entry", ch_state, 16'h5555);
        tick();
        chk("status_hunt", state_status, 4'b0010);
        while (cyc < 256) tick();
        chk("pre_lock", ch_state, 16'h5555);
        tick();
        chk("lock_all", ch_state, 16'hAAAA);
        chk("led_lock", led, 8'hFF);
        tick();
        chk("status_lock", state_status, 4'b0100);

        // channel 3: three errors keep lock, fourth drops it
        err = 8'h08; tick(); err = '0;
        chk("led_err_off", led, 8'hF7);
        tick();
        chk("led_err_on", led, 8'hFF);
        for (int k = 0; k < 2; k++) begin
            err = 8'h08; tick(); err = '0; tick();
        end
        chk("ch3_3err_state", st(3), 2);
        chk("ch3_3err_cnt", ec(3), 3);
        err = 8'h08; tick(); err = '0;
        chk("ch3_lost", st(3), 3);
        chk("ch3_4err_cnt", ec(3), 4);
        tick();
        chk("status_lost", state_status, 4'b1000);
        seen0 = 1'b0; seen1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (led[3]) seen1 = 1'b1; else seen0 = 1'b1;
        end
        chk("lost_blink", {seen0, seen1}, 2'b11);
        chk("led_others", led & 8'hF7, 8'hF7);

        // invalid cycles ignore the error strobe
        vld = 8'hDF; err = 8'h20; tick(); vld = 8'hFF; err = '0;
        chk("ch5_invalid_cnt", ec(5), 0);
        chk("ch5_invalid_led", led[5], 1);

        // channel 4: error on last window cycle (edge 1281) then 3 more
        while (cyc < 1280) tick();
        err = 8'h10; tick(); err = '0;
        chk("ch4_edge_state", st(4), 2);
        chk("ch4_edge_cnt", ec(4), 1);
        for (int k = 0; k < 3; k++) begin
            tick(); err = 8'h10; tick(); err = '0;
        end
        chk("ch4_nextwin_state", st(4), 2);
        chk("ch4_nextwin_cnt", ec(4), 4);

        // saturation in LOST
        for (int k = 0; k < 20; k++) begin
            err = 8'h08; tick(); err = '0; tick();
        end
        chk("ch3_sat", ec(3), 15);
        chk("ch3_sat_state", st(3), 3);

        // clear coinciding with an error
        clr = 1'b1; tick();
        err = 8'h08; tick(); err = '0;
        chk("clr_cnt3", ec(3), 0);
        chk("clr_state3", st(3), 1);
        chk("clr_cnt4", ec(4), 0);
        chk("clr_state4", st(4), 2);
        err = 8'h40; tick(); err = '0;
        chk("clr_held_once", ec(6), 1);
        clr = 1'b0;

        // HUNT error at run count 255
        repeat (254) tick();
        chk("hunt_255", st(3), 1);
        err = 8'h08; tick(); err = '0;
        chk("hunt_err_state", st(3), 1);
        chk("hunt_err_nocnt", ec(3), 0);
        repeat (255) tick();
        chk("relock_pre", st(3), 1);
        tick();
        chk("relock", st(3), 2);

        // inject edge detection
        repeat (3) tick();
        inj = 1'b1; tick();
        chk("inj_lat1", inject_pulse, 0);
        tick();
        chk("inj_pulse", inject_pulse, 1);
        chk("inj_status", state_status, 4'b0101);
        tick();
        chk("inj_width", inject_pulse, 0);
        npulse = 0;
        for (int k = 0; k < 97; k++) begin
            tick();
            if (inject_pulse) npulse++;
        end
        chk("inj_held", npulse, 0);
        inj = 1'b0; repeat (3) tick();
        inj = 1'b1; tick(); tick();
        chk("inj_second", inject_pulse, 1);
        tick(); inj = 1'b0;

        // disable channel 5
        en = 8'hDF; tick();
        chk("dis5_state", ch_state, 16'hA2AA);
        chk("dis5_led", led, 8'hDF);
        tick();
        chk("dis5_status", state_status, 4'b0100);
        chk("dis5_cnt6", ec(6), 1);

        // asynchronous reset mid-operation
        rst_n = 1'b0; #1;
        chk("arst_state", ch_state, 0);
        chk("arst_cnt", err_cnt, 0);
        chk("arst_led", led, 0);
        chk("arst_status", state_status, 0);
        chk("arst_pulse", inject_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
